// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core's memory-port arbiter.
package core_mem_pkg;

  // Width of the registered memory request bundle; the arbiter's XLEN must match it.
  localparam int unsigned MEM_XLEN = 32;

  // Access size encodings carried on the mask lines.
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_XLEN-1:0] wr_data;
    logic [1:0]          mask;
    logic                wr_en;
  } mem_req_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data has fixed priority; a streak limit forces a fetch grant so fetch always
// progresses. One transaction at a time, with an idle cycle between grants.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int unsigned XLEN       = MEM_XLEN,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_instr_addr,
  input  logic            i_instr_req,
  output logic [XLEN-1:0] o_instr_data,
  output logic            o_instr_ack,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wr_data,
  input  logic [1:0]      i_data_mask,
  input  logic            i_data_wr_en,
  input  logic            i_data_req,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic            o_data_ack,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic [1:0]      o_mem_mask,
  output logic            o_mem_wr_en,
  output logic            o_mem_req,
  input  logic [XLEN-1:0] i_mem_rd_data,
  input  logic            i_mem_ack
);

  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  arb_state_e          r_state, w_state;
  mem_req_t            r_mem, w_mem;
  logic                r_mem_req, w_mem_req;
  logic [STREAK_W-1:0] r_streak, w_streak;
  logic                r_drop, w_drop;

  logic                w_grant_data;
  logic [STREAK_W-1:0] w_streak_inc;

  // Data wins unless fetch is waiting and has already been passed over MAX_STREAK times.
  assign w_grant_data = i_data_req & (~i_instr_req | (r_streak < STREAK_MAX));
  assign w_streak_inc = (r_streak < STREAK_MAX) ? r_streak + STREAK_W'(1) : r_streak;

  // Next-state: arbitrate in idle, hold the bus bundle until the memory acks.
  always_comb begin
    w_state   = r_state;
    w_mem     = r_mem;
    w_mem_req = r_mem_req;
    w_streak  = r_streak;
    w_drop    = r_drop;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_grant_data) begin
          w_state   = ARB_DATA;
          w_mem_req = 1'b1;
          w_mem     = '{addr: i_data_addr, wr_data: i_data_wr_data,
                        mask: i_data_mask, wr_en: i_data_wr_en};
          w_streak  = i_instr_req ? w_streak_inc : '0;
        end else if (i_instr_req) begin
          w_state   = ARB_INSTR;
          w_mem_req = 1'b1;
          w_mem     = '{addr: i_instr_addr, wr_data: '0, mask: MEM_WORD, wr_en: 1'b0};
          w_streak  = '0;
          // A flush on the grant edge already targets this fetch.
          w_drop    = i_flush;
        end else begin
          w_streak  = '0;
        end
      end
      ARB_INSTR: begin
        if (i_flush) w_drop = 1'b1;
        if (i_mem_ack) begin
          w_state   = ARB_IDLE;
          w_mem_req = 1'b0;
          w_drop    = 1'b0;
        end
      end
      ARB_DATA: begin
        if (i_mem_ack) begin
          w_state   = ARB_IDLE;
          w_mem_req = 1'b0;
        end
      end
      default: begin
        w_state   = ARB_IDLE;
        w_mem_req = 1'b0;
        w_drop    = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ARB_IDLE;
      r_mem     <= '0;
      r_mem_req <= 1'b0;
      r_streak  <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mem     <= w_mem;
      r_mem_req <= w_mem_req;
      r_streak  <= w_streak;
      r_drop    <= w_drop;
    end
  end

  // Completion is steered combinationally to the current owner; flushed fetches stay silent.
  always_comb begin
    o_data_ack  = i_mem_ack & (r_state == ARB_DATA);
    o_instr_ack = i_mem_ack & (r_state == ARB_INSTR) & ~r_drop & ~i_flush;
  end

  assign o_instr_data   = i_mem_rd_data;
  assign o_data_rd_data = i_mem_rd_data;
  assign o_mem_addr     = r_mem.addr;
  assign o_mem_wr_data  = r_mem.wr_data;
  assign o_mem_mask     = r_mem.mask;
  assign o_mem_wr_en    = r_mem.wr_en;
  assign o_mem_req      = r_mem_req;

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one external memory port between the core's instruction-fetch interface and its load/store data interface.
- Sits between the pipeline core and the single-ported memory/bus. Serialises one transaction at a time.
- Fixed priority goes to data. A configurable starvation limit guarantees forward progress for fetch.
- A flush input drops an in-flight fetch response after a taken branch.

Parameters:
- XLEN, 32, address/data width.
- MAX_STREAK, 4, max consecutive data grants while fetch is pending before fetch is forced; must be >= 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_instr_addr  in  XLEN  fetch address
- i_instr_req  in  1  fetch request, held until ack
- o_instr_data  out  XLEN  fetch read data
- o_instr_ack  out  1  fetch complete, one-cycle pulse
- i_flush  in  1  discard in-flight fetch response
- i_data_addr  in  XLEN  load/store address
- i_data_wr_data  in  XLEN  store data
- i_data_mask  in  2  access size (00 byte, 01 half, 10 word)
- i_data_wr_en  in  1  1=store, 0=load
- i_data_req  in  1  data request, held until ack
- o_data_rd_data  out  XLEN  load data
- o_data_ack  out  1  data complete, one-cycle pulse
- o_mem_addr  out  XLEN  memory address (registered)
- o_mem_wr_data  out  XLEN  memory write data (registered)
- o_mem_mask  out  2  memory size (registered)
- o_mem_wr_en  out  1  memory write enable (registered)
- o_mem_req  out  1  memory request (registered)
- i_mem_rd_data  in  XLEN  memory read data, valid with ack
- i_mem_ack  in  1  memory done, variable latency >= 1 cycle after o_mem_req

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values:
  - All o_mem_* outputs are 0.
  - o_instr_ack = 0 and o_data_ack = 0.
  - State is ARB_IDLE; streak counter is 0; drop flag is 0.
  - Reset mid-transaction abandons it silently; no ack is issued afterwards.
- State ARB_IDLE (o_mem_req=0), arbitrating in this order:
  - If data req and (instr req = 0 or streak < MAX_STREAK): grant data, go to ARB_DATA.
  - Else if instr req: grant instr, go to ARB_INSTR.
  - Else: stay in ARB_IDLE.
- On grant, the winner's addr/wr_data/mask/wr_en are registered onto o_mem_*. o_mem_req=1 from the next cycle, giving one cycle of request-to-bus latency.
  - Fetch grants drive o_mem_wr_en=0, o_mem_mask=2'b10, o_mem_wr_data=0.
- States ARB_DATA / ARB_INSTR:
  - o_mem_req and all o_mem_* are held stable until i_mem_ack=1.
  - In the ack cycle, the FSM returns to ARB_IDLE and o_mem_req drops at the next edge.
  - There is always one idle cycle between transactions. A requester's held req is never re-granted in its own ack cycle.
- Ack paths are combinational:
  - o_data_ack = i_mem_ack & (state == ARB_DATA).
  - o_instr_ack = i_mem_ack & (state == ARB_INSTR) & ~drop & ~i_flush.
  - o_instr_data and o_data_rd_data = i_mem_rd_data (unqualified; valid only with the corresponding ack).
- Streak counter:
  - Increments on each data grant made while i_instr_req=1, saturating at MAX_STREAK.
  - Clears on an instr grant, or in ARB_IDLE when i_instr_req=0.
- Flush:
  - i_flush in ARB_INSTR sets drop; drop clears on leaving ARB_INSTR.
  - The memory transaction still completes; only the ack is suppressed.
  - i_flush in ARB_IDLE or ARB_DATA has no effect.
  - i_flush coincident with the grant edge (ARB_IDLE, instr winning) sets drop for the new transaction.
- i_mem_ack while in ARB_IDLE is ignored.
- Requesters must hold req and attributes stable until ack. A req dropped before grant is simply not granted.

Decomposition:
- Package core_mem_pkg holds:
  - enum arb_state_e {ARB_IDLE, ARB_INSTR, ARB_DATA};
  - packed struct mem_req_t {addr, wr_data, mask, wr_en};
  - size constants MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
- Single module; no sub-module is needed.

Test Plan:
- Fetch only: instr_req=1, addr 0x100; mem acks 3 cycles after o_mem_req with 0x00500093 -> o_mem_req high 1 cycle after req, o_mem_addr=0x100, o_instr_ack single pulse with data 0x00500093, then o_mem_req=0 for 1 cycle.
- Store: data_req, addr 0x2000, wr_data 0xDEADBEEF, mask 2'b10, wr_en=1; ack after 5 cycles -> o_mem_* constant through all 5 cycles, o_data_ack single pulse, o_instr_ack stays 0.
- Simultaneous one-shot requests (data 0x40, instr 0x104) -> data served first, 1 idle cycle, then instr served.
- Starvation: both reqs held high continuously, MAX_STREAK=4, 1-cycle memory -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Flush: i_flush pulsed 1 cycle after fetch grant -> memory still acked, o_instr_ack never asserts, next fetch (0x200) granted and acked normally.
- Reset mid-store: assert i_rst_n=0 while in ARB_DATA -> o_mem_req=0 immediately (asynchronous), no o_data_ack; a later i_mem_ack in ARB_IDLE is ignored.
